// File: rtl/cr_iu_gated_clk_reg_rd.sv
// cr_iu_gated_clk_reg_rd
// Read port for the IU gated-clock register bank. Each accepted request snapshots
// one register, or the write data of a same-cycle write to that index (the write
// wins). The result goes into a 2-entry response queue with a valid/ready handshake.
// Optional build macro: CR_IU_GPR_RD_WRITE_SNOOP_EN. When it is defined, a write
// to an index also updates every queued in-range entry for that index, so queued
// data follows the bank.
module cr_iu_gated_clk_reg_rd #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int DATA_W   = 32
) (
  input  logic                       forever_cpuclk,
  input  logic                       cpurst,
  input  logic                       rd_req_vld,
  input  logic [IDX_W-1:0]           rd_req_idx,
  output logic                       rd_req_rdy,
  input  logic [NUM_REGS*DATA_W-1:0] reg_bank_dout,
  input  logic                       x_write_en,
  input  logic [IDX_W-1:0]           x_write_idx,
  input  logic [DATA_W-1:0]          write_data,
  output logic                       rd_rsp_vld,
  input  logic                       rd_rsp_rdy,
  output logic [DATA_W-1:0]          rd_rsp_data,
  output logic [IDX_W-1:0]           rd_rsp_idx,
  output logic                       rd_rsp_err,
  output logic                       rd_busy
);

  // Widened by one bit so that NUM_REGS == 2^IDX_W can still be compared.
  localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] data_r [2];
  logic [IDX_W-1:0]  idx_r  [2];
  logic [1:0]        err_r;
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;

  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] bank_sel_s;
  logic [DATA_W-1:0] cap_data_s;
  logic              cap_err_s;

  // Accept is a function of queue state only; it never waits on rd_rsp_rdy.
  assign rd_req_rdy  = (count_r != 2'd2) & ~cpurst;
  assign push_s      = rd_req_vld & rd_req_rdy;
  assign rd_rsp_vld  = (count_r != 2'd0);
  assign pop_s       = rd_rsp_vld & rd_rsp_rdy;
  assign rd_busy     = rd_rsp_vld;
  assign rd_rsp_data = data_r[rd_ptr_r];
  assign rd_rsp_idx  = idx_r[rd_ptr_r];
  assign rd_rsp_err  = err_r[rd_ptr_r];

  // Select the addressed bank slice. Indices past NUM_REGS match nothing.
  always_comb begin
    bank_sel_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      bank_sel_s = (rd_req_idx == IDX_W'(i)) ? reg_bank_dout[i*DATA_W +: DATA_W] : bank_sel_s;
    end
  end

  // Data captured on accept. The range check comes first, so an out-of-range
  // write index can never bypass.
  always_comb begin
    cap_data_s = {DATA_W{1'b0}};
    cap_err_s  = 1'b0;
    if ({1'b0, rd_req_idx} >= NUM_REGS_C) begin
      cap_data_s = {DATA_W{1'b0}};
      cap_err_s  = 1'b1;
    end else if (x_write_en && (x_write_idx == rd_req_idx)) begin
      cap_data_s = write_data;
      cap_err_s  = 1'b0;
    end else begin
      cap_data_s = bank_sel_s;
      cap_err_s  = 1'b0;
    end
  end

`ifdef CR_IU_GPR_RD_WRITE_SNOOP_EN
  logic [1:0] ent_vld_s;

  // Mark which queue slots hold live entries: the head slot, plus the other slot when full.
  always_comb begin
    ent_vld_s            = 2'b00;
    ent_vld_s[rd_ptr_r]  = (count_r != 2'd0);
    ent_vld_s[~rd_ptr_r] = (count_r == 2'd2);
  end
`endif

  // Queue storage, pointers and occupancy. Reset discards every entry.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      for (int e = 0; e < 2; e++) begin
        data_r[e] <= {DATA_W{1'b0}};
        idx_r[e]  <= {IDX_W{1'b0}};
      end
      err_r    <= 2'b00;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
`ifdef CR_IU_GPR_RD_WRITE_SNOOP_EN
      // Keep live entries in step with the bank. A slot popped this edge is
      // already presented with its pre-write value.
      for (int e = 0; e < 2; e++) begin
        if (x_write_en && ent_vld_s[e] && !err_r[e] && (idx_r[e] == x_write_idx)) begin
          data_r[e] <= write_data;
        end
      end
`endif
      if (push_s) begin
        data_r[wr_ptr_r] <= cap_data_s;
        idx_r[wr_ptr_r]  <= rd_req_idx;
        err_r[wr_ptr_r]  <= cap_err_s;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
